// File: rtl/bus_mux_pkg.sv
// Shared types and constant helpers for the bus source arbiter.
package bus_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    ARB    = 2'd2
  } state_e;

  // Ceiling log2 for sizing index fields at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_src_arbiter_if.sv
// Source-select bus bundle: control/request/data towards the arbiter, selected bus back.
interface bus_src_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_SRC = 4,
  parameter int SEL_W = bus_mux_pkg::clog2(N_SRC)
);
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_SRC-1:0]       req;
  logic                   lock;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [N_SRC-1:0]       grant;
  logic [SEL_W-1:0]       grant_idx;

  modport master (
    output mode, sel, req, lock, data_in,
    input  bus_out, bus_valid, grant, grant_idx
  );

  modport slave (
    input  mode, sel, req, lock, data_in,
    output bus_out, bus_valid, grant, grant_idx
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping, with a mask of excluded sources.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int SEL_W = bus_mux_pkg::clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_SRC-1:0] excl,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_SRC-1:0] cand_req;
  int               cand;

  assign cand_req = req & ~excl;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    // i runs 1..N_SRC so the pointer itself is the last candidate considered
    for (int i = 1; i <= N_SRC; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!found && cand_req[cand]) begin
        found = 1'b1;
        idx   = SEL_W'(cand);
      end
    end
  end
endmodule

// File: rtl/bus_src_arbiter.sv
// N-source shared-bus selector with registered output: direct select or round-robin arbitration.
module bus_src_arbiter
  import bus_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_SRC    = 4,
  parameter int MAX_HOLD = 4,
  parameter int SEL_W    = clog2(N_SRC)
) (
  input logic              clk,
  input logic              rst,
  bus_src_arbiter_if.slave bus
);
  localparam int HOLD_W = clog2(MAX_HOLD + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bus_q, bus_d;
  logic              valid_q, valid_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  gidx_q, gidx_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [WIDTH-1:0]  src [N_SRC];
  logic              sel_ok, at_limit, forced, release_g;
  logic [N_SRC-1:0]  pick_excl;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src[gi] = bus.data_in[gi*WIDTH +: WIDTH];
  end

  // In ARB rr_q always equals the current owner, so one pointer serves both searches.
  assign sel_ok    = int'(bus.sel) < N_SRC;
  assign at_limit  = int'(hold_q) >= MAX_HOLD - 1;
  assign forced    = !bus.lock && at_limit && |(bus.req & ~grant_q);
  assign release_g = !(|(bus.req & grant_q)) || forced;
  assign pick_excl = (state_q == ARB && forced) ? grant_q : '0;

  rr_pick #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_rr_pick (
    .req   (bus.req),
    .ptr   (rr_q),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    bus_d   = '0;
    valid_d = 1'b0;
    grant_d = '0;
    gidx_d  = '0;
    hold_d  = hold_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (!bus.mode) begin
          state_d = DIRECT;
        end else if (pick_found) begin
          state_d = ARB;
          bus_d   = src[pick_idx];
          valid_d = 1'b1;
          grant_d = N_SRC'(1) << pick_idx;
          gidx_d  = pick_idx;
          rr_d    = pick_idx;
        end
      end
      DIRECT: begin
        if (bus.mode) begin
          state_d = IDLE;
        end else if (sel_ok) begin
          bus_d   = src[bus.sel];
          valid_d = 1'b1;
          grant_d = N_SRC'(1) << bus.sel;
          gidx_d  = bus.sel;
        end
      end
      ARB: begin
        if (!release_g) begin
          bus_d   = src[gidx_q];
          valid_d = 1'b1;
          grant_d = grant_q;
          gidx_d  = gidx_q;
          hold_d  = at_limit ? hold_q : hold_q + HOLD_W'(1);
        end else if (bus.mode && pick_found) begin
          bus_d   = src[pick_idx];
          valid_d = 1'b1;
          grant_d = N_SRC'(1) << pick_idx;
          gidx_d  = pick_idx;
          rr_d    = pick_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bus_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      gidx_q  <= '0;
      hold_q  <= '0;
      rr_q    <= SEL_W'(N_SRC - 1);
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.bus_out   = bus_q;
  assign bus.bus_valid = valid_q;
  assign bus.grant     = grant_q;
  assign bus.grant_idx = gidx_q;
endmodule

// File: tb/tb_bus_src_arbiter.sv
// Scoreboard bench: directed steps queue expected bus state; a monitor checks after each edge.
module tb_bus_src_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_src_arbiter_if #(.WIDTH(8), .N_SRC(4)) ifa ();
  bus_src_arbiter_if #(.WIDTH(8), .N_SRC(3)) ifb ();

  bus_src_arbiter #(.WIDTH(8), .N_SRC(4), .MAX_HOLD(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  bus_src_arbiter #(.WIDTH(8), .N_SRC(3), .MAX_HOLD(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    bit         dut;
    logic [7:0] bus;
    logic       valid;
    logic [3:0] grant;
    logic [1:0] gidx;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   tag   = 0;

  // Queue the outputs expected after the coming rising edge, then move to the next falling edge.
  task automatic step(input bit d, input logic [7:0] b, input logic v,
                      input logic [3:0] g, input logic [1:0] gi);
    exp_t e;
    e.dut = d; e.bus = b; e.valid = v; e.grant = g; e.gidx = gi; e.tag = tag;
    exp_q.push_back(e);
    tag++;
    @(negedge clk);
  endtask

  task automatic step_n(input int n, input bit d, input logic [7:0] b, input logic v,
                        input logic [3:0] g, input logic [1:0] gi);
    for (int k = 0; k < n; k++) step(d, b, v, g, gi);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] a_bus;
    logic       a_v;
    logic [3:0] a_g;
    logic [1:0] a_gi;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut) begin
          a_bus = ifb.bus_out; a_v = ifb.bus_valid; a_g = {1'b0, ifb.grant}; a_gi = ifb.grant_idx;
        end else begin
          a_bus = ifa.bus_out; a_v = ifa.bus_valid; a_g = ifa.grant; a_gi = ifa.grant_idx;
        end
        total++;
        if (a_bus !== e.bus || a_v !== e.valid || a_g !== e.grant || a_gi !== e.gidx) begin
          bad++;
          $display("FAIL step%0d dut%0d: got bus=%h valid=%b grant=%b idx=%0d, want bus=%h valid=%b grant=%b idx=%0d",
                   e.tag, e.dut, a_bus, a_v, a_g, a_gi, e.bus, e.valid, e.grant, e.gidx);
        end else begin
          $display("ok   step%0d dut%0d: bus=%h valid=%b grant=%b idx=%0d",
                   e.tag, e.dut, a_bus, a_v, a_g, a_gi);
        end
      end
    end
  end

  initial begin : stimulus
    ifa.mode = 1'b0; ifa.sel = 2'd2; ifa.req = '0; ifa.lock = 1'b0;
    ifa.data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
    ifb.mode = 1'b0; ifb.sel = 2'd0; ifb.req = '0; ifb.lock = 1'b0;
    ifb.data_in = {8'hB2, 8'hB1, 8'hB0};

    // Reset held three cycles, then DIRECT sel=2
    rst = 1'b1;
    step_n(3, 0, 8'h00, 0, 4'b0000, 2'd0);
    rst = 1'b0;
    step(0, 8'h00, 0, 4'b0000, 2'd0);
    step(0, 8'hA5, 1, 4'b0100, 2'd2);
    ifa.sel = 2'd0; step(0, 8'h11, 1, 4'b0001, 2'd0);
    ifa.sel = 2'd3; step(0, 8'h44, 1, 4'b1000, 2'd3);

    // DIRECT with three sources: out-of-range select gives an invalid bus
    ifb.sel = 2'd3; step(1, 8'h00, 0, 4'b0000, 2'd0);
    ifb.sel = 2'd1; step(1, 8'hB1, 1, 4'b0010, 2'd1);
    ifb.sel = 2'd2; step(1, 8'hB2, 1, 4'b0100, 2'd2);
    ifb.sel = 2'd3; step(1, 8'h00, 0, 4'b0000, 2'd0);

    // ARB from reset, req=1010: rotation every MAX_HOLD cycles without a bubble
    rst = 1'b1; ifa.mode = 1'b1; ifa.req = 4'b1010;
    step(0, 8'h00, 0, 4'b0000, 2'd0);
    rst = 1'b0;
    step_n(4, 0, 8'h22, 1, 4'b0010, 2'd1);
    step_n(4, 0, 8'h44, 1, 4'b1000, 2'd3);
    step(0, 8'h22, 1, 4'b0010, 2'd1);

    // Lock keeps owner 1 well past MAX_HOLD; dropping its request still releases
    ifa.lock = 1'b1;
    step_n(10, 0, 8'h22, 1, 4'b0010, 2'd1);
    ifa.req = 4'b1000;
    step_n(2, 0, 8'h44, 1, 4'b1000, 2'd3);
    ifa.lock = 1'b0; ifa.req = 4'b0000;
    step(0, 8'h00, 0, 4'b0000, 2'd0);

    // Single requester: held indefinitely, released to IDLE, then regranted
    ifa.req = 4'b0001;
    step_n(6, 0, 8'h11, 1, 4'b0001, 2'd0);
    ifa.req = 4'b0000; step(0, 8'h00, 0, 4'b0000, 2'd0);
    ifa.req = 4'b0001; step(0, 8'h11, 1, 4'b0001, 2'd0);

    // Reset mid-burst with owner 0: the next search must restart at source 0
    ifa.req = 4'b1001; rst = 1'b1;
    step(0, 8'h00, 0, 4'b0000, 2'd0);
    rst = 1'b0;
    step_n(4, 0, 8'h11, 1, 4'b0001, 2'd0);
    step(0, 8'h44, 1, 4'b1000, 2'd3);

    // Leaving ARB finishes the current grant, then IDLE, then DIRECT
    ifa.mode = 1'b0;
    step(0, 8'h44, 1, 4'b1000, 2'd3);
    ifa.req = 4'b0001; step(0, 8'h00, 0, 4'b0000, 2'd0);
    step(0, 8'h00, 0, 4'b0000, 2'd0);
    ifa.sel = 2'd2; step(0, 8'hA5, 1, 4'b0100, 2'd2);
    // DIRECT -> ARB passes through a one-cycle invalid bubble
    ifa.mode = 1'b1; step(0, 8'h00, 0, 4'b0000, 2'd0);
    step(0, 8'h11, 1, 4'b0001, 2'd0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
